instr_axi_fetch: RTL
====================

Name: instr_axi_fetch

Overview:
Instruction fetch stage that sits directly upstream of the SIMD decoder inside the PL top level.
- After START_SIGNAL rises, it reads 32-bit instruction words from the instruction BRAM through an AXI4-Lite read master.
- Fetched words are buffered in a small FIFO and handed to the decoder over a valid/ready interface.
- Fetch stops on a HALT opcode or an AXI error; STOP_SIGNAL is raised once the buffer has drained.

Parameters:
ADDR_W, 13, AXI byte-address width into the instruction BRAM.
DATA_W, 32, instruction word width. Fixed at 32.
FIFO_DEPTH, 4, instruction buffer entries. Must be a power of 2 and at least 2.
HALT_OP, 6'h3F, opcode value in INSTR[31:26] that terminates fetch.
BASE_ADDR, 0, byte address of the first instruction.

Ports:
CLK  in  1  single clock (divided PL clock)
RSTN  in  1  synchronous, active-high reset (1 = reset)
START_SIGNAL  in  1  GPIO start level; a 0->1 edge launches a program run
STOP_SIGNAL  out  1  program finished: HALT reached or error, and buffer empty
FETCH_ERR  out  1  sticky flag: a non-OKAY RRESP was received
ARADDR  out  ADDR_W  AXI read address
ARVALID  out  1  AXI read address valid
ARREADY  in  1  AXI read address ready
RDATA  in  DATA_W  AXI read data
RRESP  in  2  AXI read response
RVALID  in  1  AXI read data valid
RREADY  out  1  AXI read data ready
INSTR  out  DATA_W  instruction to decoder (FIFO head)
INSTR_VALID  out  1  FIFO not empty
INSTR_READY  in  1  decoder accepts INSTR
PC  out  ADDR_W  byte address of the next fetch

Behaviour:
Reset (RSTN=1 at a CLK edge; synchronous, overrides everything):
- State -> IDLE.
- ARVALID=0, RREADY=0, STOP_SIGNAL=0, FETCH_ERR=0, INSTR_VALID=0, INSTR=0.
- PC=BASE_ADDR. FIFO emptied. START edge register cleared.
- Reset mid-transaction abandons any outstanding AXI read. No AXI handshake completes during reset.

Start detection:
- start_pulse = START_SIGNAL & ~start_q, where start_q is START_SIGNAL registered.
- START_SIGNAL held high from reset release counts as an edge on the first non-reset cycle.

States:
- IDLE: on start_pulse -> REQ, and clear STOP_SIGNAL and FETCH_ERR. A start_pulse in any other state is ignored.
- REQ:
  - Assert ARVALID only when FIFO free entries >= 1. At most one outstanding read.
  - ARADDR=PC, held stable while ARVALID=1 && ARREADY=0.
  - On ARVALID&&ARREADY -> RESP, and PC += 4 (wraps modulo 2^ADDR_W).
- RESP:
  - RREADY=1 (the slot was reserved in REQ).
  - On RVALID with RRESP!=2'b00: set FETCH_ERR, discard the data -> DRAIN.
  - On RVALID with RDATA[31:26]==HALT_OP: do not push the word -> DRAIN.
  - On any other RVALID: push RDATA -> REQ.
- DRAIN: ARVALID=0, RREADY=0. When the FIFO is empty -> DONE.
- DONE: STOP_SIGNAL=1, held until the next start_pulse. On start_pulse, go to REQ with PC=BASE_ADDR and clear STOP_SIGNAL/FETCH_ERR.

FIFO:
- Registered output (INSTR is the head entry).
- Push and pop in the same cycle when full is legal: the count stays unchanged.
- Pop only on INSTR_VALID&&INSTR_READY. INSTR_READY while empty has no effect.
- Space check in REQ uses count minus pop-this-cycle, so a full FIFO that pops can issue ARVALID in that same cycle.

Latency:
- start_pulse edge -> ARVALID high: 1 cycle.
- R handshake -> INSTR_VALID: 1 cycle.
- Zero-wait-state slave with the decoder always ready: 1 instruction per 2 cycles.

Decomposition:
- Package simd_fetch_pkg:
  - fetch_state_e enum: IDLE, REQ, RESP, DRAIN, DONE.
  - AXI_RESP_OKAY=2'b00 and OPCODE_MSB/LSB constants.
  - HALT_OP default.
- Sub-module instr_fifo: parameterised DATA_W/DEPTH synchronous FIFO with count output, shared with later buffering stages.

Test Plan:
1. Reset/start: RSTN=1 for 2 cycles, then START_SIGNAL 0->1 -> all outputs at reset values; ARVALID=1 with ARADDR=0 exactly 1 cycle after the edge.
2. Program fetch: BRAM holds 0x04000001, 0x04000002, 0xFC000000 (HALT), decoder ready -> INSTR sequence 0x04000001, 0x04000002; HALT never presented; STOP_SIGNAL=1 after the FIFO empties; PC=12.
3. Backpressure: INSTR_READY=0 for 20 cycles with a 10-word program -> exactly 4 words buffered, ARVALID stays 0 with a full FIFO; release -> all 10 words delivered in order with no loss or duplication.
4. AXI stalls: ARREADY delayed 3 cycles and RVALID delayed 5 cycles -> ARADDR stable during the stall; a single outstanding read; correct data order.
5. Error: RRESP=2'b10 on the 3rd read -> FETCH_ERR=1, 3rd word dropped, words 1-2 delivered, then STOP_SIGNAL=1.
6. Reset mid-read: RSTN=1 while in RESP -> state IDLE, FIFO empty, PC=0; a restart fetches from address 0 again.

Source files
------------

// File: rtl/simd_fetch_pkg.sv
`default_nettype none
// simd_fetch_pkg: state encoding and AXI/opcode constants for the instruction fetch stage.
package simd_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    RESP  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } fetch_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam int         OPCODE_MSB      = 31;
  localparam int         OPCODE_LSB      = 26;
  localparam logic [5:0] HALT_OP_DEFAULT = 6'h3F;

endpackage
`default_nettype wire

// File: rtl/instr_fifo.sv
`default_nettype none
// instr_fifo: synchronous FIFO with registered storage, occupancy count and
// simultaneous push/pop allowed when full.
module instr_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       pop,
  output logic [DATA_W-1:0]          pop_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty    = (count == '0);
  assign do_pop   = pop & ~empty;
  // A full FIFO may still accept a word when the head leaves in the same cycle.
  assign do_push  = push & ((count != (AW+1)'(DEPTH)) | do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      if (do_push && !do_pop)      count <= count + (AW+1)'(1);
      else if (!do_push && do_pop) count <= count - (AW+1)'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/instr_axi_fetch.sv
`default_nettype none
// instr_axi_fetch: AXI4-Lite instruction fetcher feeding the SIMD decoder
// through a small buffer; stops on HALT or a read error.
module instr_axi_fetch
  import simd_fetch_pkg::*;
#(
  parameter int                ADDR_W     = 13,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [5:0]        HALT_OP    = HALT_OP_DEFAULT,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START_SIGNAL,
  output logic              STOP_SIGNAL,
  output logic              FETCH_ERR,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  output logic [DATA_W-1:0] INSTR,
  output logic              INSTR_VALID,
  input  logic              INSTR_READY,
  output logic [ADDR_W-1:0] PC
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic              start_q;
  logic              start_pulse;
  logic              pop;
  logic              push;
  logic              has_space;
  logic              resp_ok;
  logic              is_halt;
  logic              fifo_empty;
  logic [CNT_W-1:0]  count;

  assign start_pulse = START_SIGNAL & ~start_q;
  assign pop         = INSTR_VALID & INSTR_READY;
  // Counting the departing head lets a full-but-draining buffer request at once.
  assign has_space   = (count != CNT_W'(FIFO_DEPTH)) | pop;
  // Handshake strobes are masked by reset so no transfer completes while in reset.
  assign ARVALID     = (state == REQ) & has_space & ~RSTN;
  assign RREADY      = (state == RESP) & ~RSTN;
  assign ARADDR      = pc;
  assign PC          = pc;
  assign resp_ok     = (RRESP == AXI_RESP_OKAY);
  assign is_halt     = (RDATA[OPCODE_MSB:OPCODE_LSB] == HALT_OP);
  assign push        = RREADY & RVALID & resp_ok & ~is_halt;
  assign INSTR_VALID = ~fifo_empty;

  instr_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RSTN),
    .push      (push),
    .push_data (RDATA),
    .pop       (pop),
    .pop_data  (INSTR),
    .count     (count),
    .empty     (fifo_empty)
  );

  always_ff @(posedge CLK) begin
    if (RSTN) begin
      state       <= IDLE;
      pc          <= BASE_ADDR;
      start_q     <= 1'b0;
      STOP_SIGNAL <= 1'b0;
      FETCH_ERR   <= 1'b0;
    end else begin
      start_q <= START_SIGNAL;
      case (state)
        IDLE, DONE: begin
          if (start_pulse) begin
            state       <= REQ;
            pc          <= BASE_ADDR;
            STOP_SIGNAL <= 1'b0;
            FETCH_ERR   <= 1'b0;
          end
        end
        REQ: begin
          if (ARVALID && ARREADY) begin
            state <= RESP;
            pc    <= pc + ADDR_W'(4);
          end
        end
        RESP: begin
          if (RVALID) begin
            if (!resp_ok) begin
              FETCH_ERR <= 1'b1;
              state     <= DRAIN;
            end else if (is_halt) begin
              state <= DRAIN;
            end else begin
              state <= REQ;
            end
          end
        end
        DRAIN: begin
          if (fifo_empty) begin
            state       <= DONE;
            STOP_SIGNAL <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
